// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if
//  Bundles the master-side request/response signals and the shared peripheral
//  bus signals of periph_bus_arbiter.
//  Parameter N: number of bus masters.
//  Signals:
//   req[N], we[N]        per-master request and write/read select
//   addr[32*N], wdata    per-master address / write data, master i at [32*i+31:32*i]
//   gnt[N], done[N]      one-hot accept and completion pulses
//   rdata[32], busy      read data (valid with done of a read), arbiter busy
//   sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r   peripheral bus outputs
//   sys_r_line           peripheral read data
//  Modports: slave = arbiter side, master = masters/peripheral side.
interface periph_bus_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [32*N-1:0] addr;
  logic [32*N-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [31:0]    rdata;
  logic           busy;
  logic [31:0]    sys_w_addr;
  logic [31:0]    sys_r_addr;
  logic [31:0]    sys_w_line;
  logic [31:0]    sys_r_line;
  logic           sys_w;
  logic           sys_r;

  modport slave (
    input  req, we, addr, wdata, sys_r_line,
    output gnt, done, rdata, busy, sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r
  );

  modport master (
    output req, we, addr, wdata, sys_r_line,
    input  gnt, done, rdata, busy, sys_w_addr, sys_r_addr, sys_w_line, sys_w, sys_r
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
//  Round-robin arbiter sharing one peripheral bus between N masters. Each grant
//  runs a single write (1 bus cycle) or a single read (READ_LAT bus cycles).
//  All outputs are registered; nothing combinational reaches an output from
//  the request inputs.
//  Parameters: N (2..8) masters, READ_LAT (1..15) read strobe cycles.
//  Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      periph_bus_arbiter_if.slave (requests, responses, peripheral bus)
module periph_bus_arbiter #(
  parameter int N        = 4,
  parameter int READ_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  periph_bus_arbiter_if.slave   bus
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_last;
  logic [IDXW-1:0] r_win;
  logic [3:0]      r_cnt;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    r_done;
  logic [31:0]     r_rdata;
  logic [31:0]     r_sys_w_addr;
  logic [31:0]     r_sys_r_addr;
  logic [31:0]     r_sys_w_line;
  logic            r_sys_w;
  logic            r_sys_r;

  logic            w_found;
  logic [IDXW-1:0] w_winner;
  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_cand;
  logic            w_we;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [N-1:0]    w_win_onehot;
  logic [N-1:0]    w_done_onehot;

  // Search last+1, last+2, ... wrapping mod N; the extra sum bit keeps the
  // wrap correct for N that is not a power of two.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, r_last} + (IDXW+1)'(k);
      if (w_sum >= (IDXW+1)'(N)) begin
        w_sum = w_sum - (IDXW+1)'(N);
      end
      w_cand = w_sum[IDXW-1:0];
      if (!w_found && bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Select the winning master's command fields.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == IDXW'(i)) begin
        w_we    = bus.we[i];
        w_addr  = bus.addr[32*i +: 32];
        w_wdata = bus.wdata[32*i +: 32];
      end
    end
  end

  assign w_win_onehot  = {{(N-1){1'b0}}, 1'b1} << w_winner;
  assign w_done_onehot = {{(N-1){1'b0}}, 1'b1} << r_win;

  // done is cleared on every IDLE edge, so it lives exactly for the IDLE cycle
  // that follows a transaction, which is also the next arbitration cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_last       <= IDXW'(N-1);
      r_win        <= '0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_rdata      <= '0;
      r_sys_w_addr <= '0;
      r_sys_r_addr <= '0;
      r_sys_w_line <= '0;
      r_sys_w      <= 1'b0;
      r_sys_r      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (w_found) begin
            r_last <= w_winner;
            r_win  <= w_winner;
            r_gnt  <= w_win_onehot;
            if (w_we) begin
              r_state      <= WR;
              r_sys_w      <= 1'b1;
              r_sys_w_addr <= w_addr;
              r_sys_w_line <= w_wdata;
            end else begin
              r_state      <= RD;
              r_sys_r      <= 1'b1;
              r_sys_r_addr <= w_addr;
              r_cnt        <= 4'(READ_LAT - 1);
            end
          end
        end
        WR: begin
          r_gnt   <= '0;
          r_sys_w <= 1'b0;
          r_done  <= w_done_onehot;
          r_state <= IDLE;
        end
        RD: begin
          r_gnt <= '0;
          if (r_cnt == 4'd0) begin
            r_rdata <= bus.sys_r_line;
            r_sys_r <= 1'b0;
            r_done  <= w_done_onehot;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.rdata      = r_rdata;
  assign bus.busy       = (r_state != IDLE);
  assign bus.sys_w_addr = r_sys_w_addr;
  assign bus.sys_r_addr = r_sys_r_addr;
  assign bus.sys_w_line = r_sys_w_line;
  assign bus.sys_w      = r_sys_w;
  assign bus.sys_r      = r_sys_r;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter
//  Drives periph_bus_arbiter with directed and random traffic and compares
//  every cycle against a transaction-timeline model of the arbiter.
module tb_periph_bus_arbiter;

  localparam int N = 4;
  localparam int L = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  periph_bus_arbiter_if #(.N(N)) bus ();

  periph_bus_arbiter #(.N(N), .READ_LAT(L)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [N-1:0]    reqD   = '0;
  logic [N-1:0]    weD    = '0;
  logic [32*N-1:0] addrD  = '0;
  logic [32*N-1:0] wdataD = '0;
  logic [31:0]     rlineD = '0;

  assign bus.req        = reqD;
  assign bus.we         = weD;
  assign bus.addr       = addrD;
  assign bus.wdata      = wdataD;
  assign bus.sys_r_line = rlineD;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  // Transaction-timeline model: one active transaction with its start edge.
  int  p       = 0;
  int  nextArb = 0;
  int  tStart  = 0;
  int  curM    = 0;
  bit  curWe   = 1'b0;
  bit  haveTx  = 1'b0;
  int  mLast   = N - 1;
  int  pend [N];

  logic [N-1:0] eGnt   = '0;
  logic [N-1:0] eDone  = '0;
  logic [31:0]  eRdata = '0;
  logic         eBusy  = 1'b0;
  logic         eSysW  = 1'b0;
  logic         eSysR  = 1'b0;
  logic [31:0]  eWAddr = '0;
  logic [31:0]  eRAddr = '0;
  logic [31:0]  eWLine = '0;

  function automatic logic bitAt(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] o;
    o = {{(N-1){1'b0}}, 1'b1} << i;
    return o;
  endfunction

  function automatic logic [31:0] word(input logic [32*N-1:0] v, input int i);
    logic [32*N-1:0] t;
    t = v >> (32 * i);
    return t[31:0];
  endfunction

  function automatic int idxOf(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) begin
      if (bitAt(v, i)) r = i;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    p = 0; nextArb = 0; tStart = 0; curM = 0; curWe = 1'b0; haveTx = 1'b0;
    mLast = N - 1;
    eGnt = '0; eDone = '0; eRdata = '0; eBusy = 1'b0; eSysW = 1'b0; eSysR = 1'b0;
    eWAddr = '0; eRAddr = '0; eWLine = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  // One clock edge of the model, using the inputs the bench drove before it.
  task automatic modelStep();
    int dur;
    int m;
    int c;
    p++;
    eGnt = '0; eDone = '0; eSysW = 1'b0; eSysR = 1'b0; eBusy = 1'b0;
    if (haveTx) begin
      dur = curWe ? 1 : L;
      if (!curWe && p == tStart + L) eRdata = rlineD;
      if (p == tStart + dur) begin
        eDone  = onehot(curM);
        haveTx = 1'b0;
      end else begin
        eBusy = 1'b1;
        eSysW = curWe;
        eSysR = !curWe;
      end
    end
    if (!haveTx && p >= nextArb && reqD != '0) begin
      m = -1;
      for (int k = 1; k <= N; k++) begin
        c = (mLast + k) % N;
        if (m < 0 && bitAt(reqD, c)) m = c;
      end
      mLast  = m;
      curM   = m;
      curWe  = bitAt(weD, m);
      tStart = p;
      nextArb = p + (curWe ? 1 : L) + 1;
      haveTx = 1'b1;
      eGnt   = onehot(m);
      eBusy  = 1'b1;
      if (curWe) begin
        eSysW  = 1'b1;
        eWAddr = word(addrD, m);
        eWLine = word(wdataD, m);
      end else begin
        eSysR  = 1'b1;
        eRAddr = word(addrD, m);
      end
    end
  endtask

  task automatic checkOutput();
    cmp("gnt",        32'(bus.gnt),        32'(eGnt));
    cmp("done",       32'(bus.done),       32'(eDone));
    cmp("rdata",      bus.rdata,           eRdata);
    cmp("busy",       32'(bus.busy),       32'(eBusy));
    cmp("sys_w",      32'(bus.sys_w),      32'(eSysW));
    cmp("sys_r",      32'(bus.sys_r),      32'(eSysR));
    cmp("sys_w_addr", bus.sys_w_addr,      eWAddr);
    cmp("sys_r_addr", bus.sys_r_addr,      eRAddr);
    cmp("sys_w_line", bus.sys_w_line,      eWLine);
    cmp("strobe_excl", 32'(bus.sys_w & bus.sys_r), 32'd0);
    cmp("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (bitAt(bus.gnt, i)) pend[i]++;
      if (bitAt(bus.done, i)) begin
        cmp("done_matches_gnt", 32'(pend[i] > 0), 32'd1);
        if (pend[i] > 0) pend[i]--;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelStep();
    @(negedge clk);
  endtask

  task automatic setMaster(input int i, input logic [31:0] a, input logic [31:0] d);
    logic [32*N-1:0] mask;
    mask   = {{(32*N-32){1'b0}}, 32'hFFFF_FFFF} << (32 * i);
    addrD  = (addrD & ~mask)  | ({{(32*N-32){1'b0}}, a} << (32 * i));
    wdataD = (wdataD & ~mask) | ({{(32*N-32){1'b0}}, d} << (32 * i));
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] w);
    reqD = r;
    weD  = w;
  endtask

  // Asserts reset between edges, checks the immediate effect, releases on a negedge.
  task automatic doReset(input bit checkNow);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    if (checkNow) begin
      cmp("rst_sys_r", 32'(bus.sys_r), 32'd0);
      cmp("rst_busy",  32'(bus.busy),  32'd0);
      cmp("rst_gnt",   32'(bus.gnt),   32'd0);
      cmp("rst_done",  32'(bus.done),  32'd0);
      cmp("rst_rdata", bus.rdata,      32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  int gIdx[$];
  int gCyc[$];
  int expOrder[5] = '{0, 1, 2, 3, 0};

  initial begin
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkEn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during a read, then first grant goes to master 0.
    setMaster(2, 32'h0000_0030, 32'h0);
    rlineD = 32'hDEAD_BEEF;
    applyStimulus(4'b0100, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();
    cmp("t1_in_read", 32'(bus.sys_r), 32'd1);
    doReset(1'b1);
    for (int i = 0; i < N; i++) setMaster(i, 32'h100 + 32'(i), 32'h200 + 32'(i));
    applyStimulus(4'b1111, 4'b1111);
    tick();
    cmp("t1_first_gnt", 32'(bus.gnt), 32'h1);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    tick();

    // Single write from master 1.
    setMaster(1, 32'h0000_000A, 32'h5A5A_0001);
    applyStimulus(4'b0010, 4'b0010);
    tick();
    cmp("t2_gnt",    32'(bus.gnt),   32'h2);
    cmp("t2_sys_w",  32'(bus.sys_w), 32'd1);
    cmp("t2_waddr",  bus.sys_w_addr, 32'h0000_000A);
    cmp("t2_wline",  bus.sys_w_line, 32'h5A5A_0001);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    cmp("t2_done",   32'(bus.done),  32'h2);
    cmp("t2_sys_w0", 32'(bus.sys_w), 32'd0);
    tick();

    // Read from master 2 with 3-cycle latency.
    setMaster(2, 32'h0000_000C, 32'h0);
    rlineD = 32'h0000_1234;
    applyStimulus(4'b0100, 4'b0000);
    tick();
    cmp("t3_gnt",   32'(bus.gnt),   32'h4);
    cmp("t3_sys_r1", 32'(bus.sys_r), 32'd1);
    cmp("t3_raddr", bus.sys_r_addr, 32'h0000_000C);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    cmp("t3_sys_r2", 32'(bus.sys_r), 32'd1);
    tick();
    cmp("t3_sys_r3", 32'(bus.sys_r), 32'd1);
    tick();
    cmp("t3_done",  32'(bus.done),  32'h4);
    cmp("t3_rdata", bus.rdata,      32'h0000_1234);
    cmp("t3_sys_r0", 32'(bus.sys_r), 32'd0);
    tick();

    // Round-robin order with all masters writing continuously.
    @(negedge clk);
    doReset(1'b0);
    applyStimulus(4'b1111, 4'b1111);
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (bus.gnt != '0) begin
        gIdx.push_back(idxOf(bus.gnt));
        gCyc.push_back(t);
      end
    end
    applyStimulus(4'b0000, 4'b0000);
    cmp("t4_count", 32'(gIdx.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < gIdx.size()) cmp("t4_order", 32'(gIdx[i]), 32'(expOrder[i]));
      if (i > 0 && i < gCyc.size()) cmp("t4_spacing", 32'(gCyc[i] - gCyc[i-1]), 32'd2);
    end
    tick();
    tick();

    // Contention: m3 arrives during an m0 read and wins the next arbitration.
    setMaster(0, 32'h0000_0020, 32'h0);
    setMaster(3, 32'h0000_0040, 32'h3333_0003);
    rlineD = 32'h0000_ABCD;
    applyStimulus(4'b0001, 4'b0000);
    tick();
    cmp("t5_gnt0", 32'(bus.gnt), 32'h1);
    applyStimulus(4'b1001, 4'b1000);
    tick();
    tick();
    tick();
    cmp("t5_done0", 32'(bus.done), 32'h1);
    tick();
    cmp("t5_gnt3", 32'(bus.gnt), 32'h8);
    applyStimulus(4'b0001, 4'b0000);
    tick();
    cmp("t5_done3", 32'(bus.done), 32'h8);
    tick();
    cmp("t5_gnt0b", 32'(bus.gnt), 32'h1);
    applyStimulus(4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) tick();

    // Random traffic with one mid-run reset.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) reqD = '0;
      else reqD = N'($urandom());
      weD    = N'($urandom());
      rlineD = $urandom();
      for (int i = 0; i < N; i++) setMaster(i, $urandom(), $urandom());
      if (c == 5000) doReset(1'b1);
      else tick();
    end

    applyStimulus(4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < N; i++) cmp("pending_at_end", 32'(pend[i]), 32'd0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
